// File: rtl/nbit_div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX stage uses the master modport; the divider uses the slave modport.
interface nbit_div_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/nbit_div_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// It takes one quotient bit per cycle, MSB first, and registers the result for writeback.
module nbit_div_unit #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    nbit_div_unit_if.slave div_if
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

    state_t        state_reg, state_next;
    logic [CW-1:0] counter_reg, counter_next;
    logic [N:0]    rem_reg, rem_next;
    logic [N-1:0]  quo_reg, quo_next;
    logic [N-1:0]  divisor_reg, divisor_next;
    logic          neg_q_reg, neg_q_next;
    logic          neg_r_reg, neg_r_next;
    logic          is_rem_reg, is_rem_next;
    logic [N-1:0]  result_reg, result_next;

    logic          signed_op, rem_op, a_neg, b_neg, div_zero, overflow;
    logic [N-1:0]  a_mag, b_mag;
    logic [N:0]    shifted, diff, rem_step;
    logic [N-1:0]  quo_step, rem_low, q_fin, r_fin;

    // Operand decode for a request presented this cycle
    always_comb begin
        signed_op = ~div_if.op[0];
        rem_op    = div_if.op[1];
        a_neg     = signed_op & div_if.a[N-1];
        b_neg     = signed_op & div_if.b[N-1];
        a_mag     = a_neg ? -div_if.a : div_if.a;
        b_mag     = b_neg ? -div_if.b : div_if.b;
        div_zero  = (div_if.b == '0);
        overflow  = signed_op && (div_if.a == INT_MIN) && (div_if.b == '1);
    end

    // One restoring step: the remainder never exceeds the divisor, so N bits
    // plus one borrow bit are enough for the trial subtraction.
    always_comb begin
        shifted  = {rem_reg[N-1:0], quo_reg[N-1]};
        diff     = shifted - {1'b0, divisor_reg};
        rem_step = diff[N] ? shifted : diff;
        quo_step = {quo_reg[N-2:0], ~diff[N]};
        rem_low  = rem_step[N-1:0];
        q_fin    = neg_q_reg ? -quo_step : quo_step;
        r_fin    = neg_r_reg ? -rem_low : rem_low;
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        divisor_next = divisor_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        is_rem_next  = is_rem_reg;
        result_next  = result_reg;

        case (state_reg)
            CALC: begin
                rem_next     = rem_step;
                quo_next     = quo_step;
                counter_next = counter_reg - 1'b1;
                // The step that brings the counter to zero also finishes the op
                if (counter_reg == CW'(1)) begin
                    result_next = is_rem_reg ? r_fin : q_fin;
                    state_next  = DONE;
                end
            end
            default: begin
                state_next = IDLE;
                if (div_if.start) begin
                    if (div_zero) begin
                        result_next = rem_op ? div_if.a : '1;
                        state_next  = DONE;
                    end else if (overflow) begin
                        result_next = rem_op ? '0 : div_if.a;
                        state_next  = DONE;
                    end else begin
                        rem_next     = '0;
                        quo_next     = a_mag;
                        divisor_next = b_mag;
                        neg_q_next   = ~rem_op & (a_neg ^ b_neg);
                        neg_r_next   = rem_op & a_neg;
                        is_rem_next  = rem_op;
                        counter_next = CW'(N);
                        state_next   = CALC;
                    end
                end
            end
        endcase

        // Abort wins over both a new request and a finishing step
        if (div_if.flush) begin
            state_next   = IDLE;
            counter_next = '0;
            result_next  = result_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            is_rem_reg  <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            divisor_reg <= divisor_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            is_rem_reg  <= is_rem_next;
            result_reg  <= result_next;
        end
    end

    assign div_if.busy   = (state_reg == CALC);
    assign div_if.done   = (state_reg == DONE);
    assign div_if.result = result_reg;
endmodule

// File: tb/tb_nbit_div_unit.sv
// Directed bench for nbit_div_unit: vector table plus hand-written abort,
// ignore-while-busy and back-to-back sequences.
module tb_nbit_div_unit;
    localparam int N = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    nbit_div_unit_if #(.N(N)) bus ();

    nbit_div_unit #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after E0 with operands scrambled
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;

        n_cmp  = 0;
        n_fail = 0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[5]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[6]  = '{OP_DIVU, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1};
        vecs[7]  = '{OP_REMU, 32'h1234,       32'd0,          32'h1234,       1};
        vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[10] = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[11] = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        vecs[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[13] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  33};
        vecs[14] = '{OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          33};
        vecs[15] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[16] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33};
        vecs[17] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33};
        vecs[18] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33};
        vecs[19] = '{OP_DIVU, 32'd3,          32'd5,          32'd0,          33};
        vecs[20] = '{OP_REMU, 32'd3,          32'd5,          32'd3,          33};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);

        foreach (vecs[i]) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            $display("vec %0d op=%0d a=0x%08h b=0x%08h -> result=0x%08h lat=%0d busy=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, bus.result, lat, bcnt);
            check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat - 1));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("vec%0d_result_hold", i), bus.result, vecs[i].exp);
        end

        // start while busy is ignored
        launch(OP_DIVU, 32'd100, 32'd7);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.a     = 32'd50;
                bus.b     = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        $display("busy-start: result=0x%08h lat=%0d", bus.result, lat);
        check("busy_start_latency", 32'(lat), 32'd33);
        check("busy_start_result", bus.result, 32'd14);
        @(negedge clk);

        // flush mid-CALC
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        $display("flush: done_seen=%0d result=0x%08h", seen, bus.result);
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_result_kept", bus.result, 32'd14);
        launch(OP_DIVU, 32'd9, 32'd3);
        wait_done(lat, bcnt);
        $display("after flush DIVU 9/3: result=0x%08h lat=%0d", bus.result, lat);
        check("post_flush_result", bus.result, 32'd3);
        check("post_flush_latency", 32'(lat), 32'd33);
        @(negedge clk);

        // flush and start on the same edge: start dropped
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd40;
        bus.b     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        $display("flush+start: busy=%0d done=%0d result=0x%08h", bus.busy, bus.done, bus.result);
        check("flush_start_busy", 32'(bus.busy), 32'd0);
        check("flush_start_done", 32'(bus.done), 32'd0);
        check("flush_start_result", bus.result, 32'd3);

        // reset mid-CALC
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-calc: busy=%0d done=%0d result=0x%08h", bus.busy, bus.done, bus.result);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", bus.result, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("midreset_no_done", 32'(seen), 32'd0);

        // back-to-back: start on the done cycle of the previous op
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, bcnt);
        $display("b2b first: result=0x%08h lat=%0d", bus.result, lat);
        check("b2b_first_result", bus.result, 32'd14);
        check("b2b_first_latency", 32'(lat), 32'd33);
        launch(OP_REM, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        $display("b2b second: result=0x%08h lat=%0d", bus.result, lat);
        check("b2b_second_result", bus.result, 32'hFFFF_FFFF);
        check("b2b_second_latency", 32'(lat), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
